fpu_op_arbiter: RTL
===================

// Module: fpu_op_arbiter
// PURPOSE
//  Shares one pipelined FPU datapath (align/operate/normalize, fixed latency) between
//  NUM_REQ requesters. Picks one request per cycle round-robin and drives the FPU issue port.
//  Tracks each in-flight op's owner in a tag pipeline and steers each result back to its owner.
//  Provides a drain/halt sequence so software can quiesce the FPU.
// PARAMETERS
//  NUM_REQ   2  requester count, legal 2..4
//  PIPE_LAT  3  FPU issue-to-result latency in cycles, legal 1..8
// PORTS
//  clk        in   1            rising-edge clock
//  rst        in   1            synchronous active-high reset
//  req_valid  in   NUM_REQ      per-requester op valid
//  req_ready  out  NUM_REQ      per-requester grant (one-hot or zero)
//  req_a      in   32*NUM_REQ   operand A, IEEE-754 single; requester i at [32i+31:32i]
//  req_b      in   32*NUM_REQ   operand B, same packing
//  req_op     in   2*NUM_REQ    operator: 2'b00 add, 2'b10 mul; 01/11 unsupported
//  halt_req   in   1            request drain, then stop issuing
//  halted     out  1            pipeline empty and issue stopped
//  fpu_valid  out  1            issue strobe to FPU
//  fpu_a      out  32           FPU operand A
//  fpu_b      out  32           FPU operand B
//  fpu_op     out  2            FPU operator
//  fpu_res    in   32           FPU result, valid PIPE_LAT cycles after fpu_valid
//  rsp_valid  out  NUM_REQ      one-hot result strobe to owner
//  rsp_data   out  32           result, shared by all requesters
//  rsp_err    out  1            with rsp_valid: op was unsupported, rsp_data = 0
// BEHAVIOUR
//  Reset: all outputs 0; FSM = RUN; RR pointer = 0; tag pipeline cleared.
//  FSM: RUN  -> DRAIN when halt_req=1.
//       DRAIN -> HALT when tag pipeline is empty.
//       HALT  -> RUN when halt_req=0.
//       DRAIN/HALT issue nothing; req_ready = 0.
//  Arbitration (RUN only, combinational):
//  - Grant the first valid requester at or after ptr, wrapping modulo NUM_REQ.
//  - req_ready[i] = 1 only for the winner; transfer = req_valid & req_ready.
//  - On a transfer, ptr <= winner+1 (wraps NUM_REQ-1 -> 0). No transfer: ptr holds.
//  Issue:
//  - The cycle after a transfer: fpu_valid = 1; fpu_a/b/op are the registered operands.
//  - No transfer: fpu_valid = 0 and the operands hold their values.
//  - Unsupported op: still occupies an issue slot, but fpu_valid = 0 for that slot.
//  Tag pipeline:
//  - PIPE_LAT+1 stages of {v, err, id[1:0]}, advancing every cycle; no stall.
//  - Stage PIPE_LAT pairs with fpu_res.
//  - Response: rsp_valid[id] = v and rsp_data = fpu_res (0 if err), both registered.
//  - Total latency: req transfer -> rsp_valid = PIPE_LAT+2 cycles.
//  - Requesters must always accept responses; no backpressure.
//  Boundaries:
//  - Sustained throughput: one op per cycle.
//  - All requesters valid: each requester is granted once every NUM_REQ cycles.
//  - halt_req in the same cycle as a request: the request is not granted.
//  - Ops issued before halt still return.
//  - halted = 1 only in HALT.
//  - rst mid-flight: tags cleared; in-flight results are dropped with no rsp_valid.
//  - fpu_res is ignored when stage v = 0.
// CONFIGURATION
//  FPU_ARB_STATS_EN defined:
//  - Adds outputs stat_issued (32, total transfers) and stat_conflict (32, cycles with
//    >1 req_valid and a grant); both saturate at 0xFFFFFFFF and are cleared by rst.
//  FPU_ARB_STATS_EN undefined: ports and counters are absent. Other behaviour is identical.
// TESTING
//  1. Req0 add A=0x3F800000 B=0x40000000 -> rsp_valid=01 at cycle PIPE_LAT+2; rsp_data=0x40400000; rsp_err=0.
//  2. Req0 and req1 valid continuously for 8 cycles -> grants alternate 0,1,0,1...; 8 responses, each to its own owner, in order.
//  3. Req1 op=2'b01 -> fpu_valid stays 0; rsp_valid=10 and rsp_err=1 with rsp_data=0 at cycle PIPE_LAT+2.
//  4. 3 ops in flight, then halt_req=1 -> req_ready=0; 3 responses arrive; halted=1 the cycle after the last; halt_req=0 resumes.
//  5. rst pulsed with 2 ops in flight -> no rsp_valid ever; ptr=0; next request granted normally.
//  6. With FPU_ARB_STATS_EN: test 2 gives stat_issued=8 and stat_conflict=8.

Source files
------------

// File: rtl/fpu_op_arbiter_if.sv
// Handshake and datapath bundle between requesters/FPU (master) and fpu_op_arbiter (slave).
interface fpu_op_arbiter_if #(
  parameter int unsigned NUM_REQ = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic [2*NUM_REQ-1:0]  req_op;
  logic                  halt_req;
  logic                  halted;
  logic                  fpu_valid;
  logic [31:0]           fpu_a;
  logic [31:0]           fpu_b;
  logic [1:0]            fpu_op;
  logic [31:0]           fpu_res;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [31:0]           rsp_data;
  logic                  rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_op, halt_req, fpu_res,
    input  req_ready, halted, fpu_valid, fpu_a, fpu_b, fpu_op, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, halt_req, fpu_res,
    output req_ready, halted, fpu_valid, fpu_a, fpu_b, fpu_op, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/fpu_op_arbiter.sv
// Round-robin arbiter sharing one fixed-latency FPU, with owner tag pipeline and drain/halt.
// Optional FPU_ARB_STATS_EN adds saturating issue/conflict counters.
module fpu_op_arbiter #(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned PIPE_LAT = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  fpu_op_arbiter_if.slave        bus
`ifdef FPU_ARB_STATS_EN
  ,
  output logic [31:0]            stat_issued,
  output logic [31:0]            stat_conflict
`endif
);

  localparam logic [1:0] StRun   = 2'd0;
  localparam logic [1:0] StDrain = 2'd1;
  localparam logic [1:0] StHalt  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [1:0]         ptr_q;
  logic [1:0]         winner;
  logic               found;
  logic [3:0]         valid4;
  logic [2:0]         idx_sum;
  logic [NUM_REQ-1:0] ready_d;
  logic [31:0]        sel_a, sel_b;
  logic [1:0]         sel_op;
  logic               unsupported;

  logic               fpu_valid_q;
  logic [31:0]        fpu_a_q, fpu_b_q;
  logic [1:0]         fpu_op_q;

  logic [PIPE_LAT:0]  tag_v_q, tag_err_q;
  logic [1:0]         tag_id_q [PIPE_LAT+1];

  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_data_q;
  logic               rsp_err_q;

  // Padded to four so the wrapped index can address it for any legal NUM_REQ.
  always_comb begin
    valid4  = 4'(bus.req_valid);
    found   = 1'b0;
    winner  = 2'd0;
    idx_sum = 3'd0;
    if (!rst && state_q == StRun && !bus.halt_req) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        idx_sum = {1'b0, ptr_q} + 3'(k);
        if (idx_sum >= 3'(NUM_REQ)) idx_sum = idx_sum - 3'(NUM_REQ);
        if (!found && valid4[idx_sum[1:0]]) begin
          found  = 1'b1;
          winner = idx_sum[1:0];
        end
      end
    end
  end

  always_comb begin
    ready_d = '0;
    sel_a   = 32'h0;
    sel_b   = 32'h0;
    sel_op  = 2'b00;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      ready_d[i] = found && (winner == 2'(i));
      if (winner == 2'(i)) begin
        sel_a  = bus.req_a[32*i +: 32];
        sel_b  = bus.req_b[32*i +: 32];
        sel_op = bus.req_op[2*i +: 2];
      end
    end
  end

  // Only add (00) and mul (10) reach the FPU.
  assign unsupported = sel_op[0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      StRun:   if (bus.halt_req)   state_d = StDrain;
      StDrain: if (tag_v_q == '0)  state_d = StHalt;
      StHalt:  if (!bus.halt_req)  state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    rsp_valid_d = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rsp_valid_d[i] = tag_v_q[PIPE_LAT] && (tag_id_q[PIPE_LAT] == 2'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      ptr_q       <= 2'd0;
      fpu_valid_q <= 1'b0;
      fpu_a_q     <= 32'h0;
      fpu_b_q     <= 32'h0;
      fpu_op_q    <= 2'b00;
      tag_v_q     <= '0;
      tag_err_q   <= '0;
      for (int unsigned s = 0; s <= PIPE_LAT; s++) tag_id_q[s] <= 2'd0;
      rsp_valid_q <= '0;
      rsp_data_q  <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fpu_valid_q <= found && !unsupported;
      if (found) begin
        ptr_q    <= (winner == 2'(NUM_REQ - 1)) ? 2'd0 : winner + 2'd1;
        fpu_a_q  <= sel_a;
        fpu_b_q  <= sel_b;
        fpu_op_q <= sel_op;
      end
      tag_v_q     <= {tag_v_q[PIPE_LAT-1:0], found};
      tag_err_q   <= {tag_err_q[PIPE_LAT-1:0], found && unsupported};
      tag_id_q[0] <= winner;
      for (int unsigned s = 1; s <= PIPE_LAT; s++) tag_id_q[s] <= tag_id_q[s-1];
      // Last tag stage lines up with fpu_res; anything without a live tag is discarded.
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= tag_v_q[PIPE_LAT] && tag_err_q[PIPE_LAT];
      rsp_data_q  <= (tag_v_q[PIPE_LAT] && !tag_err_q[PIPE_LAT]) ? bus.fpu_res : 32'h0;
    end
  end

  assign bus.req_ready = ready_d;
  assign bus.halted    = (state_q == StHalt);
  assign bus.fpu_valid = fpu_valid_q;
  assign bus.fpu_a     = fpu_a_q;
  assign bus.fpu_b     = fpu_b_q;
  assign bus.fpu_op    = fpu_op_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

`ifdef FPU_ARB_STATS_EN
  logic multi_valid;
  assign multi_valid = (bus.req_valid & (bus.req_valid - NUM_REQ'(1))) != '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued   <= 32'h0;
      stat_conflict <= 32'h0;
    end else begin
      if (found && stat_issued != 32'hFFFF_FFFF) stat_issued <= stat_issued + 32'd1;
      if (found && multi_valid && stat_conflict != 32'hFFFF_FFFF) begin
        stat_conflict <= stat_conflict + 32'd1;
      end
    end
  end
`endif

endmodule
